// File: rtl/branch_resolver_if.sv
// Branch-prediction bus between the predictor/EX stage (master) and the resolver (slave).
interface branch_resolver_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            pred_valid_id;
  logic [PC_W-1:0] pc_now_id;
  logic            prediction_id;
  logic [PC_W-1:0] pred_target_id;
  logic            branch_exists_ex;
  logic [PC_W-1:0] pc_now_ex;
  logic            branch_decision_ex;
  logic [PC_W-1:0] branch_target_ex;
  logic            stall_id;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            orphan_err;
  logic [CW-1:0]   queue_count;

  modport master (
    output pred_valid_id, pc_now_id, prediction_id, pred_target_id,
    output branch_exists_ex, pc_now_ex, branch_decision_ex, branch_target_ex,
    input  stall_id, redirect, redirect_pc, flush, orphan_err, queue_count
  );

  modport slave (
    input  pred_valid_id, pc_now_id, prediction_id, pred_target_id,
    input  branch_exists_ex, pc_now_ex, branch_decision_ex, branch_target_ex,
    output stall_id, redirect, redirect_pc, flush, orphan_err, queue_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Tracks in-flight branch predictions and redirects/flushes the front end on a mispredict.
// Optional performance counters are enabled with macro BRANCH_RESOLVER_PERF_EN.
module branch_resolver #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  branch_resolver_if.slave    br_io
`ifdef BRANCH_RESOLVER_PERF_EN
  ,
  output logic [CNT_W-1:0]    branch_count_o,
  output logic [CNT_W-1:0]    mispredict_count_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("branch_resolver: illegal parameter set");
  end

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
    logic [PC_W-1:0] tgt;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q;
  logic [FW-1:0]   flush_cnt_q;
  logic            redirect_q, flush_q, orphan_q;
  logic [PC_W-1:0] redirect_pc_q;

  entry_t head;
  logic   empty, full, resolve, matched, mispredict, push;

  assign head = q_mem[rd_ptr_q];

  // Resolve/push qualification; a mispredict squashes any same-cycle push.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    resolve    = (state_q == S_RUN) && br_io.branch_exists_ex;
    matched    = resolve && !empty && (head.pc == br_io.pc_now_ex);
    mispredict = matched && ((br_io.branch_decision_ex != head.pred) ||
                             (br_io.branch_decision_ex && (br_io.branch_target_ex != head.tgt)));
    push       = (state_q == S_RUN) && br_io.pred_valid_id && (!full || matched) && !mispredict;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, matched})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_RUN;
      flush_cnt_q   <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      orphan_q      <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (mispredict) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            redirect_pc_q <= br_io.branch_decision_ex ? br_io.branch_target_ex
                                                      : br_io.pc_now_ex + PC_W'(4);
            redirect_q    <= 1'b1;
            flush_q       <= 1'b1;
            flush_cnt_q   <= FW'(FLUSH_CYCLES - 1);
            state_q       <= S_FLUSH;
          end else begin
            if (push) begin
              q_mem[wr_ptr_q] <= '{pc: br_io.pc_now_id, pred: br_io.prediction_id,
                                   tgt: br_io.pred_target_id};
              wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (matched) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (resolve && !matched) orphan_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= S_RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

`ifdef BRANCH_RESOLVER_PERF_EN
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (matched && !(&branch_cnt_q))        branch_cnt_q     <= branch_cnt_q + CNT_W'(1);
      if (mispredict && !(&mispredict_cnt_q)) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;
`endif

  assign br_io.stall_id    = full;
  assign br_io.redirect    = redirect_q;
  assign br_io.redirect_pc = redirect_pc_q;
  assign br_io.flush       = flush_q;
  assign br_io.orphan_err  = orphan_q;
  assign br_io.queue_count = count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a queue-based reference model checked every cycle.
module tb_branch_resolver;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned FC    = 2;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ent_t        mq[$];
  int          m_left;
  logic        m_redir, m_flush, m_orph;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  branch_resolver_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

`ifdef BRANCH_RESOLVER_PERF_EN
  logic [CNT_W-1:0] bc, mc;
`endif

  branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .br_io  (bus)
`ifdef BRANCH_RESOLVER_PERF_EN
    ,
    .branch_count_o     (bc),
    .mispredict_count_o (mc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply the resolver's rules to the current inputs for one clock edge.
  task automatic model_edge();
    logic hit, miss, room;
    if (!rst_n) begin
      mq.delete();
      m_left = 0; m_redir = 1'b0; m_flush = 1'b0; m_orph = 1'b0; m_rpc = '0;
      m_bc = 0; m_mc = 0;
    end else if (m_left > 0) begin
      m_redir = 1'b0;
      m_left--;
      if (m_left == 0) m_flush = 1'b0;
    end else begin
      m_redir = 1'b0;
      hit  = bus.branch_exists_ex && (mq.size() > 0) && (mq[0].pc == bus.pc_now_ex);
      miss = hit && ((bus.branch_decision_ex != mq[0].pred) ||
                     (bus.branch_decision_ex && bus.branch_target_ex != mq[0].tgt));
      if (bus.branch_exists_ex && !hit) m_orph = 1'b1;
      if (hit && m_bc < 65535) m_bc++;
      if (miss && m_mc < 65535) m_mc++;
      if (miss) begin
        mq.delete();
        m_redir = 1'b1;
        m_rpc   = bus.branch_decision_ex ? bus.branch_target_ex : bus.pc_now_ex + 32'd4;
        m_flush = 1'b1;
        m_left  = FC;
      end else begin
        room = (mq.size() < DEPTH) || hit;
        if (hit) void'(mq.pop_front());
        if (bus.pred_valid_id && room)
          mq.push_back('{pc: bus.pc_now_id, pred: bus.prediction_id, tgt: bus.pred_target_id});
      end
    end
  endtask

  task automatic compare_all();
    chk("stall",       64'(bus.stall_id),    64'(mq.size() == DEPTH));
    chk("redirect",    64'(bus.redirect),    64'(m_redir));
    chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_rpc));
    chk("flush",       64'(bus.flush),       64'(m_flush));
    chk("orphan",      64'(bus.orphan_err),  64'(m_orph));
    chk("count",       64'(bus.queue_count), 64'(mq.size()));
`ifdef BRANCH_RESOLVER_PERF_EN
    chk("branch_cnt",  64'(bc), 64'(m_bc));
    chk("mispred_cnt", 64'(mc), 64'(m_mc));
`endif
  endtask

  task automatic step(input logic pv, input logic [31:0] pcid, input logic pr, input logic [31:0] pt,
                      input logic be, input logic [31:0] pcex, input logic dec, input logic [31:0] bt);
    bus.pred_valid_id      = pv;
    bus.pc_now_id          = pcid;
    bus.prediction_id      = pr;
    bus.pred_target_id     = pt;
    bus.branch_exists_ex   = be;
    bus.pc_now_ex          = pcex;
    bus.branch_decision_ex = dec;
    bus.branch_target_ex   = bt;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] pc, input logic pr, input logic [31:0] tgt);
    step(1'b1, pc, pr, tgt, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic res(input logic [31:0] pc, input logic dec, input logic [31:0] tgt);
    step(1'b0, '0, 1'b0, '0, 1'b1, pc, dec, tgt);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    chk("rst_count",    64'(bus.queue_count), 64'd0);
    chk("rst_stall",    64'(bus.stall_id),    64'd0);
    chk("rst_redirect", 64'(bus.redirect),    64'd0);
    chk("rst_flush",    64'(bus.flush),       64'd0);
    chk("rst_rpc",      64'(bus.redirect_pc), 64'd0);
    rst_n = 1'b1;

    // Correct taken prediction
    push(32'h40, 1'b1, 32'h80);
    chk("lit_cnt1", 64'(bus.queue_count), 64'd1);
    res(32'h40, 1'b1, 32'h80);
    chk("lit_cnt0", 64'(bus.queue_count), 64'd0);
    chk("lit_noredir", 64'(bus.redirect), 64'd0);

    // Predicted not-taken, actually taken
    push(32'h40, 1'b0, 32'h0);
    res(32'h40, 1'b1, 32'h100);
    chk("lit_redir1", 64'(bus.redirect),    64'd1);
    chk("lit_rpc100", 64'(bus.redirect_pc), 64'h100);
    chk("lit_flush1", 64'(bus.flush),       64'd1);
    idle();
    chk("lit_redir_pulse", 64'(bus.redirect), 64'd0);
    chk("lit_flush2",      64'(bus.flush),    64'd1);
    idle();
    chk("lit_flush_end", 64'(bus.flush), 64'd0);

    // Predicted taken, actually not taken; younger entry squashed
    push(32'h40, 1'b1, 32'h80);
    push(32'h44, 1'b0, 32'h0);
    res(32'h40, 1'b0, 32'h0);
    chk("lit_rpc44", 64'(bus.redirect_pc), 64'h44);
    chk("lit_squash", 64'(bus.queue_count), 64'd0);
    idle(); idle();

    // Pushes and resolves during flush are ignored
    push(32'h200, 1'b1, 32'h300);
    step(1'b1, 32'h204, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h304);
    chk("lit_rpc304", 64'(bus.redirect_pc), 64'h304);
    push(32'h208, 1'b0, 32'h0);
    res(32'h60, 1'b0, 32'h0);
    chk("lit_flush_ign", 64'(bus.queue_count), 64'd0);
    chk("lit_orph_flush", 64'(bus.orphan_err), 64'd0);

    // Fill queue, drop overflow, push+pop while full
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b0, 32'h0);
    chk("lit_stall", 64'(bus.stall_id), 64'd1);
    push(32'h1F0, 1'b0, 32'h0);
    chk("lit_full4", 64'(bus.queue_count), 64'd4);
    step(1'b1, 32'h110, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("lit_full_pp", 64'(bus.queue_count), 64'd4);
    for (int i = 1; i < 5; i++) res(32'h100 + 32'(4 * i), 1'b0, 32'h0);
    chk("lit_drained", 64'(bus.queue_count), 64'd0);
    chk("lit_no_orph", 64'(bus.orphan_err),  64'd0);

    // Orphan resolve is sticky
    res(32'h60, 1'b0, 32'h0);
    chk("lit_orph1", 64'(bus.orphan_err), 64'd1);
    push(32'h70, 1'b1, 32'h90);
    res(32'h70, 1'b1, 32'h90);
    chk("lit_orph_sticky", 64'(bus.orphan_err), 64'd1);
    chk("lit_after_orph", 64'(bus.queue_count), 64'd0);

    // Reset on the first flush cycle aborts the flush
    push(32'h80, 1'b0, 32'h0);
    res(32'h80, 1'b1, 32'h90);
    chk("lit_pre_rst_flush", 64'(bus.flush), 64'd1);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("lit_rst_flush", 64'(bus.flush),    64'd0);
    chk("lit_rst_redir", 64'(bus.redirect), 64'd0);
    chk("lit_rst_orph",  64'(bus.orphan_err), 64'd0);

    // Three resolves, one mispredict
    push(32'h10, 1'b1, 32'h20);
    res(32'h10, 1'b1, 32'h20);
    chk("lit_run_after_rst", 64'(bus.redirect), 64'd0);
    push(32'h14, 1'b0, 32'h0);
    res(32'h14, 1'b0, 32'h0);
    push(32'h18, 1'b0, 32'h0);
    res(32'h18, 1'b0 ^ 1'b1, 32'h30);
    chk("lit_rpc30", 64'(bus.redirect_pc), 64'h30);
    idle(); idle();
    idle();
    chk("lit_rpc_hold", 64'(bus.redirect_pc), 64'h30);
`ifdef BRANCH_RESOLVER_PERF_EN
    chk("lit_bc3", 64'(bc), 64'd3);
    chk("lit_mc1", 64'(mc), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
